// File: rtl/acc_cpu_sequencer.sv
// Fetch/decode/execute sequencer for the accumulator machine; owns PC, IR and ACC
// and drives a single req/ack port into byte-addressed, little-endian main memory.
module acc_cpu_sequencer #(
    parameter int          DATA_W   = 16,
    parameter int          OPC_W    = 4,
    parameter int          ADDR_W   = DATA_W - OPC_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              halted,
    output logic              illegal_op,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_HALT   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;
    localparam logic [1:0] S_MEM    = 2'd3;

    localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_CLEAR = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_SKIP  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JUMP  = OPC_W'(6);

    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_acc;
    logic              r_carry;

    logic [OPC_W-1:0]  w_opc;
    logic [ADDR_W-1:0] w_x;
    logic [DATA_W:0]   w_sum;

    assign w_opc = r_ir[DATA_W-1 -: OPC_W];
    assign w_x   = r_ir[ADDR_W-1:0];
    assign w_sum = {1'b0, r_acc} + {1'b0, mem_rdata};

    // Handshake: req/addr/we/wdata are decoded from state and registers that only
    // change on an ack, so they hold steady through any number of wait cycles.
    // An ack arriving while req is low is never looked at.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_HALT;
            r_pc    <= ADDR_W'(RESET_PC);
            r_ir    <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                S_HALT: begin
                    if (start) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir    <= mem_rdata;
                        r_pc    <= r_pc + WORD_BYTES;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (w_opc)
                        OP_ADD, OP_LOAD, OP_STORE: r_state <= S_MEM;
                        OP_HALT:                   r_state <= S_HALT;
                        OP_CLEAR: begin
                            r_acc   <= '0;
                            r_state <= S_FETCH;
                        end
                        OP_SKIP: begin
                            if (r_acc == '0) begin
                                r_pc <= r_pc + WORD_BYTES;
                            end
                            r_state <= S_FETCH;
                        end
                        OP_JUMP: begin
                            r_pc    <= w_x;
                            r_state <= S_FETCH;
                        end
                        default:                   r_state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        case (w_opc)
                            OP_ADD:  {r_carry, r_acc} <= w_sum;
                            OP_LOAD: r_acc <= mem_rdata;
                            default: ;
                        endcase
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = r_pc;
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (w_opc == OP_STORE);
                mem_addr  = w_x;
                mem_wdata = r_acc;
            end
            default: ;
        endcase
    end

    assign pc         = r_pc;
    assign ir         = r_ir;
    assign acc        = r_acc;
    assign carry      = r_carry;
    assign halted     = (r_state == S_HALT);
    assign illegal_op = (r_state == S_DECODE) && (w_opc > OP_JUMP);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Bench for acc_cpu_sequencer: byte memory model with configurable wait states and a
// scoreboard of expected memory transactions, plus per-scenario register checks.
module tb_acc_cpu_sequencer;

    localparam int DATA_W = 16;
    localparam int OPC_W  = 4;
    localparam int ADDR_W = 12;
    localparam int SB_W   = 1 + ADDR_W + DATA_W;
    localparam int MAX_CYC = 1000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] acc;
    logic              carry;
    logic              halted;
    logic              illegal_op;
    logic [1:0]        dbg_state;

    logic [7:0]        mem [0:4095];
    logic [SB_W-1:0]   exp_q [$];
    int                n_checks = 0;
    int                n_fail = 0;
    int                wait_cfg = 0;
    logic              stall_en = 1'b0;
    logic [ADDR_W-1:0] stall_addr = '0;
    logic              spurious_ack = 1'b0;
    int                illegal_cnt = 0;

    acc_cpu_sequencer #(
        .DATA_W(DATA_W), .OPC_W(OPC_W), .ADDR_W(ADDR_W), .RESET_PC(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .ir(ir), .acc(acc), .carry(carry), .halted(halted),
        .illegal_op(illegal_op), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] a1;
        a1 = a + ADDR_W'(1);
        return {mem[a1], mem[a]};
    endfunction

    function automatic logic [SB_W-1:0] txn(input logic we, input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] d);
        return {we, a, d};
    endfunction

    task automatic wr_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [ADDR_W-1:0] a1;
        a1 = a + ADDR_W'(1);
        mem[a]  = d[7:0];
        mem[a1] = d[15:8];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_program(output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (halted !== 1'b1 && cycles < MAX_CYC) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // Memory responder and transaction scoreboard, evaluated away from the active edge.
    task automatic mem_model();
        logic              busy;
        int                wcnt;
        logic              lwe;
        logic [ADDR_W-1:0] la;
        logic [DATA_W-1:0] lwd;
        logic [SB_W-1:0]   act;
        logic [SB_W-1:0]   exp_v;
        busy = 1'b0;
        wcnt = 0;
        lwe = 1'b0;
        la = '0;
        lwd = '0;
        forever begin
            @(negedge clk);
            if (illegal_op === 1'b1) illegal_cnt++;
            if (mem_req === 1'b1 && !(stall_en && mem_addr == stall_addr)) begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = 0;
                    lwe = mem_we;
                    la = mem_addr;
                    lwd = mem_wdata;
                end else begin
                    n_checks++;
                    if ({mem_we, mem_addr, mem_wdata} !== {lwe, la, lwd}) begin
                        n_fail++;
                        $display("FAIL req_stable: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                                 mem_we, mem_addr, mem_wdata, lwe, la, lwd);
                    end
                end
                if (wcnt >= wait_cfg) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd_word(mem_addr);
                    act = {mem_we, mem_addr, mem_we ? mem_wdata : {DATA_W{1'b0}}};
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL txn_unexpected: got we=%b addr=%h data=%h expected none",
                                 act[SB_W-1], act[SB_W-2 -: ADDR_W], act[DATA_W-1:0]);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (act !== exp_v) begin
                            n_fail++;
                            $display("FAIL txn: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                                     act[SB_W-1], act[SB_W-2 -: ADDR_W], act[DATA_W-1:0],
                                     exp_v[SB_W-1], exp_v[SB_W-2 -: ADDR_W], exp_v[DATA_W-1:0]);
                        end
                    end
                    busy = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = DATA_W'($urandom);
                    wcnt++;
                end
            end else begin
                busy = 1'b0;
                mem_ack = spurious_ack;
                mem_rdata = DATA_W'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({halted, mem_req, mem_we, illegal_op, carry} !== 5'b10000) begin
            n_fail++;
            $display("FAIL rst_flags: got %b expected %b", {halted, mem_req, mem_we, illegal_op, carry}, 5'b10000);
        end
        n_checks++;
        if ({pc, ir, acc} !== {12'h000, 16'h0000, 16'h0000}) begin
            n_fail++;
            $display("FAIL rst_regs: got pc=%h ir=%h acc=%h expected 000/0000/0000", pc, ir, acc);
        end
        n_checks++;
        if ({mem_addr, mem_wdata} !== 28'h0) begin
            n_fail++;
            $display("FAIL rst_mem_bus: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
        end
    endtask

    task automatic load_basic_image();
        clear_mem();
        wr_word(12'h000, 16'h2010);
        wr_word(12'h002, 16'h0012);
        wr_word(12'h004, 16'h3014);
        wr_word(12'h006, 16'h1000);
        wr_word(12'h010, 16'h0005);
        wr_word(12'h012, 16'h0007);
        exp_q.push_back(txn(1'b0, 12'h000, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h010, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h002, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h012, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h004, 16'h0));
        exp_q.push_back(txn(1'b1, 12'h014, 16'h000C));
        exp_q.push_back(txn(1'b0, 12'h006, 16'h0));
    endtask

    task automatic check_basic_result(input string tag, input int cycles, input int exp_cycles);
        n_checks++;
        if (cycles !== exp_cycles) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected %0d", tag, cycles, exp_cycles);
        end
        n_checks++;
        if ({halted, pc, acc, ir, carry} !== {1'b1, 12'h008, 16'h000C, 16'h1000, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_final: got halted=%b pc=%h acc=%h ir=%h carry=%b expected 1/008/000c/1000/0",
                     tag, halted, pc, acc, ir, carry);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_txn_left: got %0d expected 0", tag, exp_q.size());
        end
    endtask

    task automatic test_program();
        int cyc;
        do_reset();
        wait_cfg = 0;
        load_basic_image();
        run_program(cyc);
        check_basic_result("prog", cyc, 11);
    endtask

    task automatic test_carry();
        int cyc;
        do_reset();
        wait_cfg = 0;
        clear_mem();
        wr_word(12'h000, 16'h2020);
        wr_word(12'h002, 16'h0022);
        wr_word(12'h004, 16'h1000);
        wr_word(12'h006, 16'h0024);
        wr_word(12'h008, 16'h1000);
        wr_word(12'h020, 16'hFFFF);
        wr_word(12'h022, 16'h0002);
        wr_word(12'h024, 16'h0001);
        exp_q.push_back(txn(1'b0, 12'h000, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h020, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h002, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h022, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h004, 16'h0));
        run_program(cyc);
        n_checks++;
        if ({cyc[7:0], acc, carry, pc} !== {8'd8, 16'h0001, 1'b1, 12'h006}) begin
            n_fail++;
            $display("FAIL add_wrap: got cyc=%0d acc=%h carry=%b pc=%h expected 8/0001/1/006", cyc, acc, carry, pc);
        end
        exp_q.push_back(txn(1'b0, 12'h006, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h024, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h008, 16'h0));
        run_program(cyc);
        n_checks++;
        if ({cyc[7:0], acc, carry, pc} !== {8'd5, 16'h0002, 1'b0, 12'h00A}) begin
            n_fail++;
            $display("FAIL add_nocarry: got cyc=%0d acc=%h carry=%b pc=%h expected 5/0002/0/00a", cyc, acc, carry, pc);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL carry_txn_left: got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_jump_skip();
        int cyc;
        do_reset();
        wait_cfg = 0;
        clear_mem();
        wr_word(12'h000, 16'h6100);
        wr_word(12'h100, 16'h5000);
        wr_word(12'h102, 16'h1000);
        wr_word(12'h104, 16'h2030);
        wr_word(12'h106, 16'h6100);
        wr_word(12'h030, 16'h0001);
        exp_q.push_back(txn(1'b0, 12'h000, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h100, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h104, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h030, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h106, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h100, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h102, 16'h0));
        run_program(cyc);
        n_checks++;
        if ({cyc[7:0], pc, acc, halted} !== {8'd13, 12'h104, 16'h0001, 1'b1}) begin
            n_fail++;
            $display("FAIL jump_skip: got cyc=%0d pc=%h acc=%h halted=%b expected 13/104/0001/1", cyc, pc, acc, halted);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL jump_skip_txn_left: got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        do_reset();
        wait_cfg = 3;
        load_basic_image();
        run_program(cyc);
        wait_cfg = 0;
        check_basic_result("wait", cyc, 32);
    endtask

    task automatic test_illegal();
        int cyc;
        do_reset();
        wait_cfg = 0;
        clear_mem();
        wr_word(12'h000, 16'h2040);
        wr_word(12'h002, 16'hF123);
        wr_word(12'h004, 16'h1000);
        wr_word(12'h040, 16'h1234);
        exp_q.push_back(txn(1'b0, 12'h000, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h040, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h002, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h004, 16'h0));
        illegal_cnt = 0;
        run_program(cyc);
        n_checks++;
        if (illegal_cnt !== 1) begin
            n_fail++;
            $display("FAIL illegal_pulse: got %0d cycles expected 1", illegal_cnt);
        end
        n_checks++;
        if ({cyc[7:0], acc, pc, carry} !== {8'd7, 16'h1234, 12'h006, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_nop: got cyc=%0d acc=%h pc=%h carry=%b expected 7/1234/006/0", cyc, acc, pc, carry);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL illegal_txn_left: got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int k;
        do_reset();
        wait_cfg = 0;
        clear_mem();
        wr_word(12'h000, 16'h2040);
        wr_word(12'h002, 16'h2050);
        wr_word(12'h040, 16'h1234);
        exp_q.push_back(txn(1'b0, 12'h000, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h040, 16'h0));
        exp_q.push_back(txn(1'b0, 12'h002, 16'h0));
        stall_addr = 12'h050;
        stall_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(mem_req === 1'b1 && mem_addr === 12'h050) && k < 100) begin
            k++;
            @(negedge clk);
        end
        n_checks++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL stall_reach: got timeout expected req to 050");
        end
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, acc, halted} !== {1'b1, 1'b0, 12'h050, 16'h1234, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold: got req=%b we=%b addr=%h acc=%h halted=%b expected 1/0/050/1234/0",
                     mem_req, mem_we, mem_addr, acc, halted);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        stall_en = 1'b0;
        n_checks++;
        if ({mem_req, halted, pc, acc, ir} !== {1'b0, 1'b1, 12'h000, 16'h0000, 16'h0000}) begin
            n_fail++;
            $display("FAIL midflight_rst: got req=%b halted=%b pc=%h acc=%h ir=%h expected 0/1/000/0000/0000",
                     mem_req, halted, pc, acc, ir);
        end
        spurious_ack = 1'b1;
        repeat (3) @(negedge clk);
        spurious_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_req, halted, pc, acc, ir} !== {1'b0, 1'b1, 12'h000, 16'h0000, 16'h0000}) begin
            n_fail++;
            $display("FAIL late_ack: got req=%b halted=%b pc=%h acc=%h ir=%h expected 0/1/000/0000/0000",
                     mem_req, halted, pc, acc, ir);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midflight_txn_left: got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_pc_wrap();
        int cyc;
        do_reset();
        wait_cfg = 0;
        clear_mem();
        wr_word(12'h000, 16'h6FFE);
        wr_word(12'hFFE, 16'h1000);
        exp_q.push_back(txn(1'b0, 12'h000, 16'h0));
        exp_q.push_back(txn(1'b0, 12'hFFE, 16'h0));
        run_program(cyc);
        n_checks++;
        if ({cyc[7:0], pc, ir, halted} !== {8'd4, 12'h000, 16'h1000, 1'b1}) begin
            n_fail++;
            $display("FAIL pc_wrap: got cyc=%0d pc=%h ir=%h halted=%b expected 4/000/1000/1", cyc, pc, ir, halted);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_txn_left: got %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        fork
            mem_model();
        join_none
        test_reset();
        test_program();
        test_carry();
        test_jump_skip();
        test_wait_states();
        test_illegal();
        test_reset_midflight();
        test_pc_wrap();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
